pixel_scan_sequencer: RTL
=========================

# pixel_scan_sequencer

Parametrised successor to the front-end scan generator. Walks the screen in raster order and emits `LANES` horizontally adjacent pixel coordinates per beat over a valid/ready stream. An optional resume gate between lines is kept, and shape-programming writes are forwarded transparently. Sits between the host/programming interface and the shape-evaluation pipeline, driving `program_out`, `x_out`, `y_out` and `data_out` into it.

## Interface
- `H_RES`, 1024: pixels per line. Must be a multiple of `LANES`.
- `V_RES`, 768: lines per frame.
- `X_W`, 11: width of `x_out` and `shape_addr`. Requires 2^X_W > H_RES.
- `Y_W`, 12: width of `y_out` and `reg_addr`. Requires 2^Y_W > V_RES.
- `DATA_W`, 12: programming data width.
- `LANES`, 1: pixels per beat (1, 2, 4 or 8). `x_out` is the leftmost pixel of the beat.
- `LINE_GATE`, 1: 1 = hold at end of each line until `resume`; 0 = free-run.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `resume`  in  1  single-cycle pulse; releases the next line.
- `program_in`  in  1  programming write strobe; has priority over scanning.
- `shape_addr`  in  X_W  programming address, forwarded on `x_out`.
- `reg_addr`  in  Y_W  programming register, forwarded on `y_out`.
- `data_in`  in  DATA_W  programming data.
- `out_ready`  in  1  downstream accepts the scan beat.
- `out_valid`  out  1  scan beat present on `x_out`/`y_out`.
- `program_out`  out  1  registered `program_in`.
- `x_out`  out  X_W  beat x, or `shape_addr` when programming.
- `y_out`  out  Y_W  beat y, or `reg_addr` when programming.
- `data_out`  out  DATA_W  `data_in` when programming, else 0.
- `line_end`  out  1  qualifies the last beat of a line (valid with `out_valid`).
- `frame_end`  out  1  qualifies the last beat of the last line.

## Operation
- State: `SCAN`, `LINE_WAIT`, `PROG`. Internal counters are `x_cnt` and `y_cnt`, plus a 1-bit `resume_pend`.
- Reset state is `SCAN` with `x_cnt = 0`, `y_cnt = 0` and `resume_pend = 0`. All outputs are 0, including `out_valid`.
- `SCAN` loads beat (`x_cnt`, `y_cnt`) into the output register and holds `out_valid` at 1.
  - Beat fields stay stable while `out_valid & !out_ready`.
  - On accept (`out_valid & out_ready`), `x_cnt += LANES`.
  - `line_end = (x_cnt == H_RES-LANES)`.
  - `frame_end = line_end & (y_cnt == V_RES-1)`.
- On accept of a `line_end` beat:
  - **Next line released** (`LINE_GATE == 0`, `resume_pend`, or `resume` this cycle): `x_cnt = 0`; `y_cnt` increments, wrapping from V_RES-1 to 0. Stay in `SCAN` and clear `resume_pend`. The next beat is loaded on the same edge, so there is no bubble.
  - **Otherwise:** go to `LINE_WAIT` with `out_valid = 0`.
- `LINE_WAIT`: the first cycle with `resume` = 1 advances the line, loads the next beat, and returns to `SCAN`.
- `resume` in `SCAN` on a non-`line_end` accept cycle sets `resume_pend`. It saturates at one; extra pulses are ignored. It is ignored when `LINE_GATE == 0`.
- `program_in` = 1 in any state enters `PROG`:
  - `out_valid` = 0 next cycle. An unaccepted beat is dropped.
  - `resume_pend` is cleared; `resume` and `out_ready` are ignored.
  - Each cycle, `program_out`/`x_out`/`y_out`/`data_out` register `1`/`shape_addr`/`reg_addr`/`data_in`.
  - No backpressure applies to writes.
- First cycle with `program_in` = 0 in `PROG`:
  - `program_out` = 0 and `data_out` = 0.
  - `x_cnt = 0`, `y_cnt = 0`. Beat (0,0) is loaded and `SCAN` is entered, so the frame is redrawn.
- Arithmetic: counters are unsigned. `x_cnt` never exceeds H_RES-LANES, and `y_cnt` never exceeds V_RES-1.
- `rst` overrides everything, including `program_in`.

## Timing
- Reset release: first edge with `rst = 0` loads beat (0,0). `out_valid = 1` in the following cycle.
- Programming latency is 1 cycle, `program_in` to `program_out`, with the fields aligned.
- Throughput is 1 beat/cycle with `out_ready` held high.
  - With `LINE_GATE = 0`: no bubbles, including at line and frame wrap.
  - With `LINE_GATE = 1`: a line without a pending resume stalls until `resume`. The next beat is valid 1 cycle after the `resume` edge.
- Scan to program: `out_valid` falls and `program_out` rises on the same edge.
- Program to scan: `program_out` falls and beat (0,0) becomes valid on the same edge.
- Simultaneous `resume` and `program_in`: program wins and `resume` is lost.

## Test plan
Bench parameters: H_RES=8, V_RES=4, LANES=2, LINE_GATE=1, `out_ready` = 1 unless stated.

- **Reset, then resume**: reset, no `resume` -> beats x = 0,2,4,6 at y = 0, `line_end` on x = 6, then `out_valid` = 0 indefinitely. `resume` pulse -> x = 0, y = 1 valid 1 cycle later.
- **Pending resume**: `resume` pulsed during beat x = 2 of every line -> 16 contiguous beats. `frame_end` only on (6,3). The next beat is (0,0) with no bubble.
- **Backpressure**: `out_ready` = 0 for 3 cycles at beat (4,1) -> `x_out` = 4 and `y_out` = 1 held. Exactly one (4,1) accept occurs.
- **Programming mid-line**: `program_in` = 1 for 2 cycles at beat (2,2), with `shape_addr` = 5/6, `reg_addr` = 9/10, `data_in` = 0xABC/0x123 -> `program_out` = 1 for 2 cycles with matching fields 1 cycle late. Then beat (0,0) with `data_out` = 0.
- **Free-run**: LINE_GATE = 0, `resume` held at 0 -> 16 back-to-back beats per frame, wrapping (6,3) -> (0,0).
- **Reset mid-operation**: `rst` asserted during `LINE_WAIT` with `resume_pend` set -> all outputs 0. After release, scan restarts at (0,0) and the first line end stalls.

Source files
------------

// File: rtl/pixel_scan_sequencer.sv
// pixel_scan_sequencer
//
// Raster-order scan generator. Each beat carries LANES horizontally adjacent
// pixels; x_out is the leftmost one. Beats leave over a valid/ready stream.
// When LINE_GATE is set, each line waits for a resume pulse before the next
// line starts, unless a resume already arrived earlier in the line. Shape
// programming writes take priority over scanning. They are forwarded with one
// cycle of latency. When programming ends, the frame restarts from (0,0).
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   resume      in   pulse that releases the next line
//   program_in  in   programming write strobe (priority over scanning)
//   shape_addr  in   [X_W]    programming address, forwarded on x_out
//   reg_addr    in   [Y_W]    programming register, forwarded on y_out
//   data_in     in   [DATA_W] programming data, forwarded on data_out
//   out_ready   in   downstream accepts the scan beat
//   out_valid   out  scan beat present on x_out/y_out
//   program_out out  registered program_in
//   x_out       out  [X_W]    beat x, or shape_addr while programming
//   y_out       out  [Y_W]    beat y, or reg_addr while programming
//   data_out    out  [DATA_W] data_in while programming, else 0
//   line_end    out  last beat of a line (qualified by out_valid)
//   frame_end   out  last beat of the last line (qualified by out_valid)
module pixel_scan_sequencer #(
  parameter int H_RES     = 1024,
  parameter int V_RES     = 768,
  parameter int X_W       = 11,
  parameter int Y_W       = 12,
  parameter int DATA_W    = 12,
  parameter int LANES     = 1,
  parameter int LINE_GATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resume,
  input  logic              program_in,
  input  logic [X_W-1:0]    shape_addr,
  input  logic [Y_W-1:0]    reg_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              program_out,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [DATA_W-1:0] data_out,
  output logic              line_end,
  output logic              frame_end
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - LANES);
  localparam logic [X_W-1:0] X_STEP = X_W'(LANES);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);
  localparam logic           GATED  = (LINE_GATE != 0);
  // Flags for beat (0,0). They only matter for degenerate 1-beat lines or frames.
  localparam logic           ORIGIN_LE = (X_LAST == '0);
  localparam logic           ORIGIN_FE = ORIGIN_LE && (Y_LAST == '0);

  typedef enum logic [1:0] {SCAN, LINE_WAIT, PROG} state_t;

  state_t         state;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           resume_pend;

  // x_cnt/y_cnt always name the beat that is (or will next be) on the output.
  // The adv_* signals give the beat that follows it in raster order.
  logic           at_line_end;
  logic           at_last_line;
  logic [X_W-1:0] adv_x;
  logic [Y_W-1:0] adv_y;
  logic           adv_le;
  logic           adv_fe;
  logic           accept;
  logic           release_line;

  always_comb begin
    at_line_end  = (x_cnt == X_LAST);
    at_last_line = (y_cnt == Y_LAST);
    adv_x        = at_line_end ? '0 : x_cnt + X_STEP;
    adv_y        = y_cnt;
    if (at_line_end)
      adv_y = at_last_line ? '0 : y_cnt + Y_ONE;
    adv_le       = (adv_x == X_LAST);
    adv_fe       = adv_le && (adv_y == Y_LAST);
    accept       = out_valid && out_ready;
    release_line = !GATED || resume_pend || resume;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      x_cnt       <= '0;
      y_cnt       <= '0;
      resume_pend <= 1'b0;
      out_valid   <= 1'b0;
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
    end else if (program_in) begin
      // Writes win in every state. A pending beat and a pending resume are dropped.
      state       <= PROG;
      resume_pend <= 1'b0;
      out_valid   <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      program_out <= 1'b1;
      x_out       <= shape_addr;
      y_out       <= reg_addr;
      data_out    <= data_in;
    end else begin
      case (state)
        SCAN: begin
          if (!out_valid) begin
            // First cycle after reset: present the current counter beat.
            out_valid <= 1'b1;
            x_out     <= x_cnt;
            y_out     <= y_cnt;
            line_end  <= at_line_end;
            frame_end <= at_line_end && at_last_line;
          end else if (out_ready) begin
            if (at_line_end && !release_line) begin
              state     <= LINE_WAIT;
              out_valid <= 1'b0;
              line_end  <= 1'b0;
              frame_end <= 1'b0;
            end else begin
              // Advance and load the next beat on the same edge (no bubble).
              x_cnt     <= adv_x;
              y_cnt     <= adv_y;
              x_out     <= adv_x;
              y_out     <= adv_y;
              line_end  <= adv_le;
              frame_end <= adv_fe;
            end
          end
          // An accepted line end consumes any pending resume. A resume at
          // any other point in SCAN is remembered for the coming line end.
          if (accept && at_line_end)
            resume_pend <= 1'b0;
          else if (resume && GATED)
            resume_pend <= 1'b1;
        end

        LINE_WAIT: begin
          // Counters still hold the last beat of the line, so adv_* is the
          // first beat of the next line.
          if (resume) begin
            state     <= SCAN;
            x_cnt     <= adv_x;
            y_cnt     <= adv_y;
            x_out     <= adv_x;
            y_out     <= adv_y;
            line_end  <= adv_le;
            frame_end <= adv_fe;
            out_valid <= 1'b1;
          end
        end

        PROG: begin
          // Programming is over. Redraw the frame from the origin.
          state       <= SCAN;
          program_out <= 1'b0;
          data_out    <= '0;
          x_cnt       <= '0;
          y_cnt       <= '0;
          x_out       <= '0;
          y_out       <= '0;
          line_end    <= ORIGIN_LE;
          frame_end   <= ORIGIN_FE;
          out_valid   <= 1'b1;
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
